// File: rtl/controle_ula.sv
// -----------------------------------------------------------------------------
// controle_ula -- multi-cycle control unit for a 16-bit register/ULA datapath.
//
// Fetches a 9-bit instruction word from the top of DIN when Run is seen in T0,
// then steps through T1..T3 to drive the bus-source selects, register load
// enables and the ULA operation code. Supported instructions:
//   000 mv  Rx,Ry   (2 cycles)   001 mvi Rx,#D  (2 cycles)
//   010 add Rx,Ry   (4 cycles)   011 sub Rx,Ry  (4 cycles)
//   100..111        no strobes, completes as a NOP (2 cycles)
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   synchronous active-high reset; forces every output to 0
//   Run       in   start request, only looked at in T0
//   DIN       in   instruction / immediate source (opcode at the top 3 bits)
//   IRin      out  load IR from the top 9 bits of DIN
//   Rin       out  one-hot load enable for R0..R(NREGS-1)
//   Rout      out  one-hot bus-drive enable for R0..R(NREGS-1)
//   Ain       out  load A from Buswires
//   Gin       out  load G from the ULA result
//   Gout      out  G drives Buswires
//   DINout    out  DIN drives Buswires
//   Operacao  out  ULA operation: 00 add, 01 sub
//   Done      out  one-cycle pulse on the last cycle of each instruction
// -----------------------------------------------------------------------------
module controle_ula #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NREGS      = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  IRin,
  output logic [NREGS-1:0]      Rin,
  output logic [NREGS-1:0]      Rout,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  Gout,
  output logic                  DINout,
  output logic [1:0]            Operacao,
  output logic                  Done
);

  localparam int unsigned IrWidth = 9;

  // Instruction opcodes (IR[8:6]).
  localparam logic [2:0] OpcMv  = 3'b000;
  localparam logic [2:0] OpcMvi = 3'b001;
  localparam logic [2:0] OpcAdd = 3'b010;
  localparam logic [2:0] OpcSub = 3'b011;

  // ULA operation codes.
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } step_e;

  step_e              step_q, step_d;
  logic [IrWidth-1:0] ir_q, ir_d;

  logic [2:0] ir_op;
  logic [2:0] ir_x;
  logic [2:0] ir_y;

  assign ir_op = ir_q[8:6];
  assign ir_x  = ir_q[5:3];
  assign ir_y  = ir_q[2:0];

  // The immediate bits below the instruction field only matter to the datapath
  // (via DINout); the control unit never looks at them.
  logic unused_din_low;
  assign unused_din_low = ^DIN[DATA_WIDTH-IrWidth-1:0];

  // Register index -> one-hot enable vector.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [2:0] idx);
    logic [NREGS-1:0] vec;
    vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (idx == 3'(i)) vec[i] = 1'b1;
    end
    return vec;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    unique case (step_q)
      StT0: begin
        if (Run) begin
          ir_d   = DIN[DATA_WIDTH-1 -: IrWidth];
          step_d = StT1;
        end
      end
      StT1: begin
        if (ir_op == OpcAdd || ir_op == OpcSub) begin
          step_d = StT2;
        end else begin
          step_d = StT0;
        end
      end
      StT2:    step_d = StT3;
      StT3:    step_d = StT0;
      default: step_d = StT0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= StT0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Everything is held at 0 while Reset is high, including the
  // Run-dependent IRin, so the datapath sees no strobe during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    IRin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Operacao = AluAdd;
    Done     = 1'b0;

    if (!Reset) begin
      // Taken from IR only, so it is already settled when A loads in T1 and
      // G loads in T2.
      Operacao = (ir_op == OpcSub) ? AluSub : AluAdd;

      unique case (step_q)
        StT0: begin
          IRin = Run;
        end
        StT1: begin
          case (ir_op)
            OpcMv: begin
              Rout = reg_onehot(ir_y);
              Rin  = reg_onehot(ir_x);
              Done = 1'b1;
            end
            OpcMvi: begin
              DINout = 1'b1;
              Rin    = reg_onehot(ir_x);
              Done   = 1'b1;
            end
            OpcAdd, OpcSub: begin
              Rout = reg_onehot(ir_x);
              Ain  = 1'b1;
            end
            default: begin
              // Unused opcode: retire as a NOP.
              Done = 1'b1;
            end
          endcase
        end
        StT2: begin
          Rout = reg_onehot(ir_y);
          Gin  = 1'b1;
        end
        StT3: begin
          Gout = 1'b1;
          Rin  = reg_onehot(ir_x);
          Done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants of the control encoding.
  // ---------------------------------------------------------------------------
  a_bus_exclusive: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0({|Rout, Gout, DINout}));

  a_rin_onehot0: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0(Rin));

  a_rout_onehot0: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0(Rout));

  a_done_returns_t0: assert property (@(posedge Clock) disable iff (Reset)
    Done |=> (step_q == StT0));

endmodule

// File: doc/controle_ula.md
Name: controle_ula

Overview:
- Multi-cycle control unit that sequences the 16-bit datapath: register file R0..R7, A register, ULA, G register and shared Buswires.
- Fetches a 9-bit instruction from DIN.
- Drives bus-source selects, register load enables and the 2-bit ULA operation code. Executes mv, mvi, add and sub in 2 or 4 cycles.
- The datapath consumes its outputs; it raises Done at the end of each instruction.

Parameters:
- DATA_WIDTH, 16, width of DIN.
- NREGS, 8, number of general registers; also the width of the Rin/Rout one-hot vectors.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  DATA_WIDTH  instruction/immediate source. Opcode = DIN[15:13], X = DIN[12:10], Y = DIN[9:7].
- IRin  output  1  load IR from DIN[15:7].
- Rin  output  NREGS  one-hot load enable for R0..R7 (all-zero when no load).
- Rout  output  NREGS  one-hot bus-drive enable for R0..R7.
- Ain  output  1  load A from Buswires.
- Gin  output  1  load G from the ULA output.
- Gout  output  1  G drives Buswires.
- DINout  output  1  DIN drives Buswires.
- Operacao  output  2  ULA operation: 00 add, 01 sub.
- Done  output  1  high for exactly one cycle, the last cycle of an instruction.

Behaviour:
- Internal state:
  - 2-bit step counter with states T0, T1, T2, T3.
  - 9-bit IR register.
- Outputs are combinational from the step counter, IR and Run (Moore, except IRin, which depends on Run in T0).
- Reset: when Reset=1 at a rising edge, step becomes T0 and IR becomes 0, whatever the current step. Reset mid-instruction aborts it with no Done.
  - While Reset=1, every output is 0: IRin, Rin, Rout, Ain, Gin, Gout, DINout and Done are 0, and Operacao=00.
- T0:
  - IRin = Run.
  - If Run=1, IR <= DIN[15:7] and step goes to T1; otherwise stay in T0.
  - No other strobe is asserted.
- T1, by IR opcode:
  - 000 mv: Rout[Y]=1, Rin[X]=1, Done=1, go to T0.
  - 001 mvi: DINout=1, Rin[X]=1, Done=1, go to T0.
  - 010 add / 011 sub: Rout[X]=1, Ain=1, go to T2.
  - 100..111 (unused): no strobes, Done=1, go to T0 (acts as a NOP).
- T2 (add/sub only): Rout[Y]=1, Gin=1, go to T3.
- T3: Gout=1, Rin[X]=1, Done=1, go to T0.
- Operacao:
  - Decoded from the IR register only: 01 when IR opcode=011, otherwise 00.
  - Stable from T1 through T3 of the instruction, so it is settled before A or Buswires change in T1/T2.
  - Never decoded directly from DIN.
- Run is ignored outside T0. With Run held high continuously, T0 follows Done immediately and a new fetch occurs every instruction with no idle cycle.
- Bus exclusivity: in every cycle, at most one of {any Rout bit, Gout, DINout} is 1. Rin and Rout are each one-hot or zero.
- mv with X=Y is legal: the register reloads its own value.
- Latency, counted from the Run=1 edge: mv/mvi/NOP Done on cycle 1; add/sub Done on cycle 3.

Test Plan:
- Reset, then Reset=0 with Run=0 for 5 cycles -> step stays T0; all outputs 0; Operacao=00; Done never asserted.
- Run=1, DIN=16'h2800 (mvi R2) -> IRin=1 in T0. Next cycle: DINout=1, Rin=8'b00000100, Done=1. Then back in T0.
- Run=1, DIN=16'h0500 (mv R1,R2) -> T1: Rout=8'b00000100, Rin=8'b00000010, Done=1. No other strobes.
- DIN=16'h4C80 (add R3,R1) -> T1: Rout=8'b00001000, Ain=1. T2: Rout=8'b00000010, Gin=1, Operacao=00. T3: Gout=1, Rin=8'b00001000, Done=1.
- DIN=16'h6380 (sub R0,R7) with Run held high -> Operacao=01 through T1-T3. T2: Rout=8'b10000000. T3: Rin=8'b00000001, Done=1. The next T0 fetches immediately (IRin=1).
- Illegal DIN=16'hC000 -> Done=1 in T1, no strobes. Separately, start add and assert Reset during T2 -> next cycle T0, all outputs 0, no Done, IR=0.
